// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
// Samples each bit at its centre using a CLK_FREQ/BAUD cycle bit-period counter.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_ferr;
  logic             w_cnt_half;
  logic             w_cnt_full;
  logic             w_shift_en;
  logic             w_load;
  logic             w_err;
  logic             w_par_ok;

  assign w_rx_s     = r_sync2;
  assign w_cnt_half = (r_cnt == HALF_LAST);
  assign w_cnt_full = (r_cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic w_par_en;

  // Capture the parity bit at its centre; even parity means it equals the XOR of the data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_par_bit <= 1'b0;
    end else if (w_par_en) begin
      r_par_bit <= w_rx_s;
    end
  end

  assign w_par_ok = (r_par_bit == ^r_shift);
`else
  assign w_par_ok = 1'b1;
`endif

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
    w_err        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en     = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (!w_rx_s) w_state_next = StStart;
      end
      StStart: begin
        // Line must still be low half a bit later, otherwise it was a glitch.
        if (w_cnt_half) w_state_next = w_rx_s ? StIdle : StData;
      end
      StData: begin
        if (w_cnt_full) begin
          w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_next = StParity;
`else
          if (r_bit_idx == 3'd7) w_state_next = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_cnt_full) begin
          w_par_en     = 1'b1;
          w_state_next = StStop;
        end
      end
`endif
      StStop: begin
        if (w_cnt_full) begin
          if (w_rx_s && w_par_ok) begin
            w_load       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_err        = 1'b1;
            // A low stop bit may be a break; wait for the line to recover first.
            w_state_next = w_rx_s ? StIdle : StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (w_rx_s) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Bit-period counter: cleared on any state change and at each bit centre.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || w_cnt_full) begin
      r_cnt <= '0;
    end else if ((r_state != StIdle) && (r_state != StWaitHigh)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // LSB-first shift register and bit index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
    end else if (w_state_next == StStart) begin
      r_bit_idx <= 3'd0;
    end else if (w_shift_en) begin
      r_shift   <= {w_rx_s, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Registered outputs: byte and strobes appear the cycle after the stop-bit decision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_load) r_byte <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_err;
    end
  end

  assign rx_byte_o   = r_byte;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a queue-based expectation model of uart_rx.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  // Stop-bit centre is 9 full bits after the start-bit centre (10 with parity).
  localparam int unsigned LATENCY = 3 + HALF + (PARITY ? 10 : 9) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rx_i       (rx),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_last = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each bit lasts exactly CPB clocks; called just after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the outcome the receiver should report, then drive the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
    exp_t e;
    e.err  = !(stop_b && (par_good || !PARITY));
    e.data = d;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY) drive_bit(par_good ? ^d : ~^d);
    drive_bit(stop_b);
  endtask

  // Every strobe must match the next queued outcome; the byte must never change otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid || frame_err) begin
        check_eq("strobe_exclusive", 32'(rx_valid & frame_err), 32'd0);
        check_eq("strobe_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("strobe_kind", 32'(frame_err), 32'(mon_e.err));
          if (rx_valid) begin
            check_eq("rx_byte", 32'(rx_byte), 32'(mon_e.data));
            model_last = mon_e.data;
          end else begin
            check_eq("byte_kept_on_err", 32'(rx_byte), 32'(model_last));
          end
        end
      end else if (rx_byte !== model_last) begin
        check_eq("byte_hold", 32'(rx_byte), 32'(model_last));
      end
    end
  end

  initial begin
    logic [7:0]  d;
    logic        stop_b;
    logic        par_good;
    int unsigned kind;
    int unsigned gap;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_byte", 32'(rx_byte), 32'h00);
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single frame with latency measured from the start-bit falling edge.
    fork
      send_frame(8'h81, 1'b1, 1'b1);
      begin
        int unsigned n;
        n = 0;
        wait (rx == 1'b0);
        while (!rx_valid && n < 12 * CPB) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
        check_eq("latency", n, LATENCY);
      end
    join

    // Back-to-back frames, no idle time between stop and next start.
    send_frame(8'hAA, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(10);
    check_eq("b2b_last_byte", 32'(rx_byte), 32'h01);

    // Short low glitch shorter than half a bit must be rejected silently.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (HALF + 2) @(posedge clk);
    #1;
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);

    // Low stop bit followed by a held-low line: error, then wait for the line to recover.
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
    check_eq("break_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("break_busy_lo", 32'(busy), 32'd0);
    check_eq("break_byte", 32'(rx_byte), 32'h01);
    idle(8);

    if (PARITY) begin
      send_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(8);
    end

    // Reset during data bit 4 of 8'hF0 discards the frame.
    d = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (HALF) @(posedge clk);
    #1;
    rst_n      = 1'b0;
    model_last = 8'h00;
    #1;
    check_eq("midrst_valid", 32'(rx_valid), 32'd0);
    check_eq("midrst_ferr", 32'(frame_err), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_byte", 32'(rx_byte), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    rx    = 1'b1;
    rst_n = 1'b1;
    idle(10);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    check_eq("post_rst_byte", 32'(rx_byte), 32'h3C);

    // Randomized traffic: mostly good frames, some stop/parity errors, random gaps.
    for (int k = 0; k < 40; k++) begin
      d        = 8'($urandom);
      kind     = $urandom_range(0, 9);
      stop_b   = (kind != 0);
      par_good = (kind != 1);
      send_frame(d, stop_b, par_good);
      if (!stop_b) begin
        repeat ($urandom_range(0, CPB)) @(posedge clk);
        #1;
        idle(8);
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      idle(gap);
    end

    idle(20);
    check_eq("pending_outcomes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (5208 at defaults).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rx_byte_o, output, 8, last correctly framed byte.
REQ-007 SHALL have port rx_valid_o, output, 1, one-cycle pulse when rx_byte_o is updated.
REQ-008 SHALL have port frame_err_o, output, 1, one-cycle pulse on a stop-bit error.
REQ-009 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, plus PARITY when the macro is defined.
REQ-012 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT), cleared on every state change.
REQ-013 IDLE: rx_s==0 -> START; otherwise stay.
REQ-014 START: at count CLKS_PER_BIT/2-1, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles (bit centre), LSB first, into a shift register; after the 8th sample -> STOP (or PARITY).
REQ-016 STOP: at the bit centre, rx_s==1 -> load rx_byte_o, pulse rx_valid_o the following cycle, -> IDLE.
REQ-017 STOP: at the bit centre, rx_s==0 -> pulse frame_err_o, leave rx_byte_o unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rx_s==1, then -> IDLE; this prevents a break condition from re-triggering a start.
REQ-019 A new start bit SHALL be accepted from IDLE immediately after the stop-bit centre (back-to-back frames, no extra idle time required).
REQ-020 rx_valid_o and frame_err_o SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 rx_byte_o SHALL hold its value between valid pulses.
REQ-022 Latency: rx_valid_o rises 1 cycle after the stop-bit centre sample, i.e. about 9.5 bit periods plus 3 cycles after the rx_i falling edge.

Reset
REQ-023 On rst_n_i low, asynchronously: state=IDLE, counter=0, shift register=0, rx_byte_o=8'h00, rx_valid_o=0, frame_err_o=0, busy_o=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL discard the partial byte with no pulse; after release, reception restarts only on a new falling edge of rx_s.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: an even-parity bit follows the data bits; the PARITY state samples it at the bit centre and then -> STOP.
REQ-026 With UART_RX_PARITY_EN, a parity mismatch SHALL suppress rx_valid_o and instead pulse frame_err_o at the stop-bit decision; rx_byte_o stays unchanged.
REQ-027 Without UART_RX_PARITY_EN: 8N1 framing, no PARITY state, no parity logic synthesized.

Verification
REQ-028 Send 8'h81 at 104.17 us/bit -> one rx_valid_o pulse, rx_byte_o=8'h81, frame_err_o stays 0.
REQ-029 Send 8'hAA then 8'h01 back-to-back with no idle gap -> two valid pulses, bytes 8'hAA then 8'h01, in order.
REQ-030 Drive rx_i low for 1 us, then high -> no pulse on either output; busy_o returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-031 Send 8'h55 with stop bit 0, holding the line low for 2 bit periods -> frame_err_o pulses, rx_byte_o keeps its previous value, busy_o stays high until the line returns high.
REQ-032 Assert rst_n_i during data bit 4 of 8'hF0, release, then send 8'h3C -> no pulse for the aborted frame; rx_byte_o=8'h3C after the second frame.
REQ-033 With UART_RX_PARITY_EN: send 8'h07 with parity 1 -> valid pulse; send 8'h07 with parity 0 -> frame_err_o pulses.
